ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//   Parametrised EX->MEM pipeline register with valid/ready handshake and a
//   2-entry skid buffer, so that MEM back-pressure never drops an EX result.
//   Supports a synchronous flush for branch/exception squash.
//   Sits between the ALU stage and the data-memory stage of the pipelined CPU.
// PARAMETERS
//   DATA_W  32  width of the ALU result and of the store data
//   RADDR_W 5   width of the destination register address
//   WB_W    2   width of the write-back control bundle (passed through)
//   MEM_W   2   width of the MEM control bundle; bit1=MemWrite, bit0=MemRead
// PORTS
//   clk_i          in   1        clock; all state updates on the rising edge only
//   rst_i          in   1        asynchronous, active-low reset
//   flush_i        in   1        synchronous squash of every held entry
//   in_valid_i     in   1        EX presents a valid instruction
//   in_ready_o     out  1        stage can accept this cycle
//   wb_i           in   WB_W     WB control in
//   mem_i          in   MEM_W    MEM control in
//   alu_out_i      in   DATA_W   ALU result in
//   mem_wdata_i    in   DATA_W   store data in
//   rd_addr_i      in   RADDR_W  destination register in
//   out_valid_o    out  1        output entry valid
//   out_ready_i    in   1        MEM consumes the output entry this cycle
//   wb_o           out  WB_W     WB control out
//   alu_out_o      out  DATA_W   ALU result out
//   mem_wdata_o    out  DATA_W   store data out
//   rd_addr_o      out  RADDR_W  destination register out
//   mem_write_o    out  1        mem_q[1] & out_valid_o
//   mem_read_o     out  1        mem_q[0] & out_valid_o
// BEHAVIOUR
// - Storage: main entry (drives the outputs) and skid entry, each with its own
//   valid bit. Both hold payload = {wb, mem, alu_out, mem_wdata, rd_addr}.
// - Reset (rst_i=0, async): both valid bits are 0; every output and payload
//   register is 0; in_ready_o is 1 once reset releases.
// - Handshakes:
//   - in_ready_o = !skid_valid. It is registered-state only, with no
//     combinational path from out_ready_i.
//   - Accept = in_valid_i & in_ready_o. Emit = out_valid_o & out_ready_i.
// - Per-cycle update, in priority order:
//   1. flush_i=1: main_valid <= 0 and skid_valid <= 0. Any input accepted that
//      cycle is discarded. Payload registers are unchanged.
//   2. Main empty, or being emitted:
//      - If skid is valid: main <= skid.
//        - If Accept is also high: skid <= input.
//        - Otherwise: skid_valid <= 0.
//      - Else, if Accept: main <= input.
//      - Else: main_valid <= 0.
//   3. Main full and not emitted: if Accept, skid <= input. Main holds.
// - Latency: 1 cycle from Accept to out_valid_o when the skid buffer is empty.
//   Full throughput is 1 instruction per cycle.
// - Ordering is strictly FIFO. The skid entry never overtakes main.
// - Capacity is 2. With both entries full, in_ready_o=0. With Accept and Emit
//   in the same cycle, occupancy is unchanged.
// - Outputs hold their value while out_valid_o & !out_ready_i.
// - mem_write_o and mem_read_o are gated by out_valid_o, so a bubble never
//   issues a memory access.
// - The WB bundle is passed through unmodified. Consumers gate it with
//   out_valid_o.
// CONFIGURATION
//   EX_MEM_FWD_EN defined: adds the following outputs, driven directly from
//   the main entry:
//     fwd_valid_o  out  1        out_valid_o & wb_q[1] (RegWrite)
//     fwd_addr_o   out  RADDR_W  rd_addr_o
//     fwd_data_o   out  DATA_W   alu_out_o
//   These ports feed the EX forwarding unit. All are 0 in reset and after a
//   flush.
//   EX_MEM_FWD_EN undefined: these ports do not exist and no logic is added.
// TESTING
// - Reset: hold rst_i=0 with random inputs -> out_valid_o=0, all outputs 0.
//   Release -> in_ready_o=1.
// - Streaming: out_ready_i=1; alu_out_i=1,2,3 on consecutive cycles with valid
//   -> alu_out_o=1,2,3 one cycle later, no bubbles.
// - Back-pressure: out_ready_i=0; send A=0x10 then B=0x20 -> out shows A,
//   in_ready_o=0, C=0x30 is not accepted. Raise out_ready_i -> A, B, C in
//   order, no loss or duplicates.
// - Flush: both entries full, pulse flush_i with in_valid_i=1 -> next cycle
//   out_valid_o=0, mem_write_o=0, in_ready_o=1.
// - Gating: mem_i=2'b11 on a bubble (in_valid_i=0) -> mem_write_o and
//   mem_read_o stay 0.
//   Valid store: mem_i=2'b10 -> mem_write_o=1 for exactly one emitted cycle.
// - EX_MEM_FWD_EN: wb_i=2'b10, rd_addr_i=5, alu_out_i=0x55 accepted ->
//   fwd_valid_o=1, fwd_addr_o=5, fwd_data_o=0x55. Same with wb_i=2'b00 ->
//   fwd_valid_o=0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
// Optional forwarding outputs are enabled by defining EX_MEM_FWD_EN.
module ex_mem_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int WB_W    = 2,
  parameter int MEM_W   = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WB_W-1:0]    wb_i,
  input  logic [MEM_W-1:0]   mem_i,
  input  logic [DATA_W-1:0]  alu_out_i,
  input  logic [DATA_W-1:0]  mem_wdata_i,
  input  logic [RADDR_W-1:0] rd_addr_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WB_W-1:0]    wb_o,
  output logic [DATA_W-1:0]  alu_out_o,
  output logic [DATA_W-1:0]  mem_wdata_o,
  output logic [RADDR_W-1:0] rd_addr_o,
  output logic               mem_write_o,
  output logic               mem_read_o
`ifdef EX_MEM_FWD_EN
  ,
  output logic               fwd_valid_o,
  output logic [RADDR_W-1:0] fwd_addr_o,
  output logic [DATA_W-1:0]  fwd_data_o
`endif
);

  typedef struct packed {
    logic [WB_W-1:0]    wb;
    logic [MEM_W-1:0]   mem;
    logic [DATA_W-1:0]  alu_out;
    logic [DATA_W-1:0]  mem_wdata;
    logic [RADDR_W-1:0] rd_addr;
  } payload_t;

  payload_t main_reg, main_next;
  payload_t skid_reg, skid_next;
  payload_t in_payload;
  logic     main_valid_reg, main_valid_next;
  logic     skid_valid_reg, skid_valid_next;
  logic     accept;
  logic     emit;

  assign in_payload = '{wb: wb_i, mem: mem_i, alu_out: alu_out_i,
                        mem_wdata: mem_wdata_i, rd_addr: rd_addr_i};

  // Ready depends only on held state so MEM back-pressure never loops back into EX.
  assign in_ready_o = !skid_valid_reg;
  assign accept     = in_valid_i & in_ready_o;
  assign emit       = main_valid_reg & out_ready_i;

  always_comb begin
    main_next       = main_reg;
    skid_next       = skid_reg;
    main_valid_next = main_valid_reg;
    skid_valid_next = skid_valid_reg;
    if (flush_i) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (!main_valid_reg || emit) begin
      if (skid_valid_reg) begin
        main_next       = skid_reg;
        main_valid_next = 1'b1;
        if (accept) begin
          skid_next = in_payload;
        end else begin
          skid_valid_next = 1'b0;
        end
      end else if (accept) begin
        main_next       = in_payload;
        main_valid_next = 1'b1;
      end else begin
        main_valid_next = 1'b0;
      end
    end else if (accept) begin
      skid_next       = in_payload;
      skid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      main_reg       <= '0;
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else begin
      main_reg       <= main_next;
      skid_reg       <= skid_next;
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
    end
  end

  assign out_valid_o = main_valid_reg;
  assign wb_o        = main_reg.wb;
  assign alu_out_o   = main_reg.alu_out;
  assign mem_wdata_o = main_reg.mem_wdata;
  assign rd_addr_o   = main_reg.rd_addr;
  // Bubbles must never reach the data memory as an access.
  assign mem_write_o = main_reg.mem[1] & main_valid_reg;
  assign mem_read_o  = main_reg.mem[0] & main_valid_reg;

`ifdef EX_MEM_FWD_EN
  // Address/data are zeroed when invalid so a flushed entry forwards nothing stale.
  assign fwd_valid_o = main_valid_reg & main_reg.wb[1];
  assign fwd_addr_o  = main_valid_reg ? main_reg.rd_addr : '0;
  assign fwd_data_o  = main_valid_reg ? main_reg.alu_out : '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage: reset, streaming, back-pressure,
// flush, memory-strobe gating and (with EX_MEM_FWD_EN) the forwarding outputs.
module tb_ex_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  wb_i;
  logic [1:0]  mem_i;
  logic [31:0] alu_out_i;
  logic [31:0] mem_wdata_i;
  logic [4:0]  rd_addr_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [1:0]  wb_o;
  logic [31:0] alu_out_o;
  logic [31:0] mem_wdata_o;
  logic [4:0]  rd_addr_o;
  logic        mem_write_o;
  logic        mem_read_o;
`ifdef EX_MEM_FWD_EN
  logic        fwd_valid_o;
  logic [4:0]  fwd_addr_o;
  logic [31:0] fwd_data_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  ex_mem_stage dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .wb_i        (wb_i),
    .mem_i       (mem_i),
    .alu_out_i   (alu_out_i),
    .mem_wdata_i (mem_wdata_i),
    .rd_addr_i   (rd_addr_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .wb_o        (wb_o),
    .alu_out_o   (alu_out_o),
    .mem_wdata_o (mem_wdata_o),
    .rd_addr_o   (rd_addr_o),
    .mem_write_o (mem_write_o),
    .mem_read_o  (mem_read_o)
`ifdef EX_MEM_FWD_EN
    ,
    .fwd_valid_o (fwd_valid_o),
    .fwd_addr_o  (fwd_addr_o),
    .fwd_data_o  (fwd_data_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-22s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] wb, input logic [1:0] mem,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
    in_valid_i  = v;
    wb_i        = wb;
    mem_i       = mem;
    alu_out_i   = alu;
    mem_wdata_i = wd;
    rd_addr_i   = rd;
  endtask

  initial begin
    // Reset held with random inputs.
    rst_i       = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    drive(1'b1, 2'($urandom), 2'($urandom), $urandom, $urandom, 5'($urandom));
    step();
    drive(1'b1, 2'($urandom), 2'($urandom), $urandom, $urandom, 5'($urandom));
    step();
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_alu_out",   64'(alu_out_o),   64'd0);
    chk("rst_wdata",     64'(mem_wdata_o), 64'd0);
    chk("rst_rd_wb",     64'({rd_addr_o, wb_o}), 64'd0);
    chk("rst_mem_strb",  64'({mem_write_o, mem_read_o}), 64'd0);
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    step();
    chk("rel_in_ready",  64'(in_ready_o),  64'd1);
    chk("rel_out_valid", 64'(out_valid_o), 64'd0);

    // Streaming with full throughput.
    out_ready_i = 1'b1;
    drive(1'b1, 2'b01, 2'b00, 32'd1, 32'hA1, 5'd1);
    step();
    chk("stream1_valid", 64'(out_valid_o), 64'd1);
    chk("stream1_alu",   64'(alu_out_o),   64'd1);
    chk("stream1_wb_rd", 64'({wb_o, rd_addr_o, mem_wdata_o}), {25'd0, 2'b01, 5'd1, 32'hA1});
    drive(1'b1, 2'b00, 2'b00, 32'd2, 32'hA2, 5'd2);
    step();
    chk("stream2_alu",   64'({out_valid_o, alu_out_o}), {31'd0, 1'b1, 32'd2});
    chk("stream2_ready", 64'(in_ready_o), 64'd1);
    drive(1'b1, 2'b00, 2'b00, 32'd3, 32'hA3, 5'd3);
    step();
    chk("stream3_alu",   64'({out_valid_o, alu_out_o}), {31'd0, 1'b1, 32'd3});
    drive(1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd0);
    step();
    chk("stream_drain",  64'(out_valid_o), 64'd0);

    // Back-pressure: A and B fill both entries, C is refused until space frees.
    out_ready_i = 1'b0;
    drive(1'b1, 2'b00, 2'b00, 32'h10, 32'h0, 5'd10);
    step();
    chk("bp_A_out",      64'({out_valid_o, alu_out_o}), {31'd0, 1'b1, 32'h10});
    chk("bp_A_ready",    64'(in_ready_o), 64'd1);
    drive(1'b1, 2'b00, 2'b00, 32'h20, 32'h0, 5'd11);
    step();
    chk("bp_B_hold_A",   64'(alu_out_o),  64'h10);
    chk("bp_full_ready", 64'(in_ready_o), 64'd0);
    drive(1'b1, 2'b00, 2'b00, 32'h30, 32'h0, 5'd12);
    step();
    chk("bp_C_refused",  64'({in_ready_o, alu_out_o, rd_addr_o}), {26'd0, 1'b0, 32'h10, 5'd10});
    out_ready_i = 1'b1;
    step();
    chk("bp_out_B",      64'({out_valid_o, alu_out_o, rd_addr_o}), {26'd0, 1'b1, 32'h20, 5'd11});
    chk("bp_ready_again", 64'(in_ready_o), 64'd1);
    step();
    chk("bp_out_C",      64'({out_valid_o, alu_out_o, rd_addr_o}), {26'd0, 1'b1, 32'h30, 5'd12});
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    step();
    chk("bp_no_dup",     64'(out_valid_o), 64'd0);

    // Flush with both entries full and a new input presented.
    out_ready_i = 1'b0;
    drive(1'b1, 2'b10, 2'b10, 32'h40, 32'hD0, 5'd4);
    step();
    drive(1'b1, 2'b10, 2'b10, 32'h50, 32'hE0, 5'd5);
    step();
    chk("fl_full",       64'({in_ready_o, mem_write_o}), 64'b01);
    flush_i = 1'b1;
    drive(1'b1, 2'b10, 2'b10, 32'h60, 32'hF0, 5'd6);
    step();
    flush_i = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    chk("fl_out_valid",  64'(out_valid_o), 64'd0);
    chk("fl_mem_write",  64'(mem_write_o), 64'd0);
    chk("fl_in_ready",   64'(in_ready_o),  64'd1);
    chk("fl_payload",    64'(alu_out_o),   64'h40);
`ifdef EX_MEM_FWD_EN
    chk("fl_fwd",        64'({fwd_valid_o, fwd_addr_o, fwd_data_o}), 64'd0);
`endif
    step();
    chk("fl_stays_empty", 64'(out_valid_o), 64'd0);

    // Memory strobe gating.
    out_ready_i = 1'b1;
    drive(1'b0, 2'b00, 2'b11, 32'h0, 32'h0, 5'd0);
    step();
    chk("gate_bubble",   64'({mem_write_o, mem_read_o}), 64'b00);
    drive(1'b1, 2'b00, 2'b10, 32'h77, 32'hCAFE, 5'd7);
    step();
    chk("store_wr",      64'({mem_write_o, mem_read_o, mem_wdata_o}), {30'd0, 2'b10, 32'hCAFE});
    drive(1'b0, 2'b00, 2'b10, 32'h0, 32'h0, 5'd0);
    step();
    chk("store_once",    64'({mem_write_o, mem_read_o}), 64'b00);
    out_ready_i = 1'b0;
    drive(1'b1, 2'b00, 2'b01, 32'h88, 32'h0, 5'd8);
    step();
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    chk("load_rd",       64'({mem_write_o, mem_read_o}), 64'b01);
    step();
    chk("load_held",     64'({mem_read_o, alu_out_o}), {31'd0, 1'b1, 32'h88});
    out_ready_i = 1'b1;
    step();
    chk("load_emitted",  64'({out_valid_o, mem_read_o}), 64'b00);

`ifdef EX_MEM_FWD_EN
    drive(1'b1, 2'b10, 2'b00, 32'h55, 32'h0, 5'd5);
    step();
    chk("fwd_on",        64'({fwd_valid_o, fwd_addr_o, fwd_data_o}), {26'd0, 1'b1, 5'd5, 32'h55});
    drive(1'b1, 2'b00, 2'b00, 32'h55, 32'h0, 5'd5);
    step();
    chk("fwd_off",       64'(fwd_valid_o), 64'd0);
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    step();
`endif

    // Asynchronous reset mid-operation clears state without a clock edge.
    out_ready_i = 1'b0;
    drive(1'b1, 2'b11, 2'b11, 32'h99, 32'h99, 5'd9);
    step();
    step();
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("async_rst",     64'({out_valid_o, in_ready_o, alu_out_o, mem_write_o}), {30'd0, 1'b0, 1'b1, 32'h0, 1'b0});
    rst_i = 1'b1;
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
